// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Hits finish in the request cycle; misses stall while the line is written back and refilled.
module dcache_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  f3,
    output logic [31:0] rdata,
    output logic        hazard,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int WBITS = $clog2(WORDS);
    localparam int IBITS = $clog2(LINES);
    localparam int TBITS = 30 - WBITS - IBITS;
    localparam logic [WBITS-1:0] LAST_BEAT = WBITS'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1, S_FILL = 2'd2, S_DONE = 2'd3} state_t;

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] fn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (fn)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] off, input logic [2:0] fn);
        logic [31:0] mask;
        logic [31:0] lanes;
        case (fn[1:0])
            2'b00: begin
                mask  = 32'h0000_00FF << {off, 3'b000};
                lanes = {4{wd[7:0]}};
            end
            2'b01: begin
                mask  = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                lanes = {2{wd[15:0]}};
            end
            default: begin
                mask  = 32'hFFFF_FFFF;
                lanes = wd;
            end
        endcase
        store_merge = (old & ~mask) | (lanes & mask);
    endfunction

    state_t                   state_q, state_d;
    logic [WBITS-1:0]         cnt_q, cnt_d;
    logic [TBITS-1:0]         lat_tag_q, lat_tag_d;
    logic [IBITS-1:0]         lat_idx_q, lat_idx_d;
    logic [LINES-1:0]         valid_q, valid_d;
    logic [LINES-1:0]         dirty_q, dirty_d;
    logic [TBITS-1:0]         tag_q  [LINES];
    logic [31:0]              data_q [LINES*WORDS];

    logic [WBITS-1:0]         req_word_s;
    logic [IBITS-1:0]         req_idx_s;
    logic [TBITS-1:0]         req_tag_s;
    logic                     req_s, hit_s, last_s;
    logic                     dwr_en_s, tag_we_s;
    logic [IBITS+WBITS-1:0]   dwr_ptr_s;
    logic [31:0]              dwr_data_s, hit_word_s;

    assign req_word_s = addr[2 +: WBITS];
    assign req_idx_s  = addr[2+WBITS +: IBITS];
    assign req_tag_s  = addr[31 -: TBITS];
    assign req_s      = memread | memwrite;
    assign hit_s      = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
    assign hit_word_s = data_q[{req_idx_s, req_word_s}];
    assign last_s     = (cnt_q == LAST_BEAT);

    // Next-state, line bookkeeping and the single data-array write port.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_tag_d  = lat_tag_q;
        lat_idx_d  = lat_idx_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        dwr_en_s   = 1'b0;
        tag_we_s   = 1'b0;
        dwr_ptr_s  = {req_idx_s, req_word_s};
        dwr_data_s = store_merge(hit_word_s, wdata, addr[1:0], f3);
        case (state_q)
            S_IDLE: begin
                if (req_s && hit_s) begin
                    if (memwrite) begin
                        dwr_en_s           = 1'b1;
                        dirty_d[req_idx_s] = 1'b1;
                    end else begin
                        dwr_en_s = 1'b0;
                    end
                end else if (req_s) begin
                    // Victim is invalidated up front so an abandoned refill never looks valid.
                    lat_tag_d          = req_tag_s;
                    lat_idx_d          = req_idx_s;
                    cnt_d              = '0;
                    valid_d[req_idx_s] = 1'b0;
                    dirty_d[req_idx_s] = 1'b0;
                    state_d = (valid_q[req_idx_s] && dirty_q[req_idx_s]) ? S_WB : S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                if (mem_ack) begin
                    if (last_s) begin
                        cnt_d   = '0;
                        state_d = S_FILL;
                    end else begin
                        cnt_d = cnt_q + WBITS'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    dwr_en_s   = 1'b1;
                    dwr_ptr_s  = {lat_idx_q, cnt_q};
                    dwr_data_s = mem_rdata;
                    if (last_s) begin
                        valid_d[lat_idx_q] = 1'b1;
                        dirty_d[lat_idx_q] = 1'b0;
                        tag_we_s           = 1'b1;
                        cnt_d              = '0;
                        state_d            = S_DONE;
                    end else begin
                        cnt_d = cnt_q + WBITS'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lat_tag_q <= '0;
            lat_idx_q <= '0;
            valid_q   <= '0;
            dirty_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_tag_q <= lat_tag_d;
            lat_idx_q <= lat_idx_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
        end
    end

    // Tag and data storage; contents are qualified by valid_q so they need no reset.
    always_ff @(posedge clk) begin
        if (dwr_en_s) begin
            data_q[dwr_ptr_s] <= dwr_data_s;
        end
        if (tag_we_s) begin
            tag_q[lat_idx_q] <= lat_tag_q;
        end
    end

    // Pipeline and memory-port outputs decoded from the registered state.
    always_comb begin
        rdata     = 32'd0;
        hazard    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    hazard = req_s && !hit_s;
                    if (memread && !memwrite && hit_s) begin
                        rdata = load_ext(hit_word_s, addr[1:0], f3);
                    end else begin
                        rdata = 32'd0;
                    end
                end
                S_WB: begin
                    hazard    = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {tag_q[lat_idx_q], lat_idx_q, cnt_q, 2'b00};
                    mem_wdata = data_q[{lat_idx_q, cnt_q}];
                end
                S_FILL: begin
                    hazard   = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {lat_tag_q, lat_idx_q, cnt_q, 2'b00};
                end
                S_DONE:  hazard = 1'b1;
                default: hazard = 1'b0;
            endcase
        end else begin
            hazard = 1'b0;
        end
    end
endmodule
